// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - start/operand/result bundle for nibble_serial_adder (Ovf with SERIAL_ADDER_OVF_EN)
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             Ovf;

  modport master (output start, A, B, Cin, input busy, done, Sum, Cout, Ovf);
  modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout, Ovf);
`else
  modport master (output start, A, B, Cin, input busy, done, Sum, Cout);
  modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout);
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder through a 4-bit slice, one nibble per clock (Ovf with SERIAL_ADDER_OVF_EN)
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic             accept;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] work, next_work;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [4:0]       slice;
  logic             last;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  // Operands shift right so the current nibble is always at bit 0.
  assign slice = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry};
  assign last  = (idx == IW'(NIBBLES - 1));

  always_comb begin
    next_work = work;
    next_work[4*int'(idx) +: 4] = slice[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept     = 1'b1;
        next_state = RUN;
      end
      RUN:  if (last) next_state = DONE;
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      work   <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.A;
      b_sh  <= bus.B;
      carry <= bus.Cin;
      idx   <= '0;
      work  <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      carry <= slice[4];
      work  <= next_work;
      idx   <= idx + 1'b1;
      if (last) begin
        sum_r  <= next_work;
        cout_r <= slice[4];
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // Carry into bit 3 of the top nibble recovered as a3 ^ b3 ^ s3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_r <= 1'b0;
    else if (!accept && state == RUN && last)
      ovf_r <= a_sh[3] ^ b_sh[3] ^ slice[3] ^ slice[4];
  end

  assign bus.Ovf = ovf_r;
`endif

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.Sum  = sum_r;
  assign bus.Cout = cout_r;
endmodule
